// File: rtl/crc_param_engine_if.sv
// Word-stream handshake bundle between the frame builder, the CRC engine and the serialiser.
// The master modport drives words in; the slave modport is the engine side.
interface crc_param_engine_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 5
);
    logic              i_enable;
    logic              i_clear;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              i_last;
    logic              o_ready;
    logic              o_busy;
    logic [CRC_W-1:0]  o_crc_value;
    logic              o_crc_valid;

    modport master (
        output i_enable, i_clear, i_data, i_data_valid, i_last,
        input  o_ready, o_busy, o_crc_value, o_crc_valid
    );

    modport slave (
        input  i_enable, i_clear, i_data, i_data_valid, i_last,
        output o_ready, o_busy, o_crc_value, o_crc_valid
    );
endinterface

// File: rtl/crc_param_engine.sv
// Parametrised CRC engine folding BITS_PER_CYC bits of each accepted word per clock.
// Defaults reproduce the I3C HDR-DDR CRC5 (x^5+x^2+1, seed all-ones, MSB first).
module crc_param_engine #(
    parameter int               CRC_W        = 5,
    parameter logic [CRC_W-1:0] POLY         = 5'h05,
    parameter logic [CRC_W-1:0] INIT         = 5'h1F,
    parameter int               DATA_W       = 8,
    parameter int               BITS_PER_CYC = 1,
    parameter bit               MSB_FIRST    = 1'b1
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    crc_param_engine_if.slave  bus
);

    localparam int N     = DATA_W / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if ((DATA_W % BITS_PER_CYC) != 0 || CRC_W < 2) begin : g_bad_params
            $error("crc_param_engine: BITS_PER_CYC must divide DATA_W and CRC_W must be >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_W-1:0]       r_word;
    logic [CRC_W-1:0]        r_crc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_last;
    logic [CRC_W-1:0]        r_crc_value;
    logic                    r_crc_valid;

    logic                    w_accept;
    logic                    w_fold;
    logic                    w_final;
    logic [BITS_PER_CYC-1:0] w_chunk;
    logic [DATA_W-1:0]       w_word_next;
    logic [CRC_W-1:0]        w_crc_folded;

    // Serial CRC update; chunk[BITS_PER_CYC-1] is the bit processed first.
    function automatic logic [CRC_W-1:0] crc_fold(
        input logic [CRC_W-1:0]        crc_in,
        input logic [BITS_PER_CYC-1:0] chunk
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ chunk[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
        return c;
    endfunction

    assign bus.o_ready     = (r_state == ST_IDLE) & bus.i_enable;
    assign bus.o_busy      = (r_state == ST_SHIFT);
    assign bus.o_crc_value = r_crc_value;
    assign bus.o_crc_valid = r_crc_valid;

    // Pick the next BITS_PER_CYC bits in processing order and advance the word register.
    always_comb begin
        w_chunk     = {BITS_PER_CYC{1'b0}};
        w_word_next = r_word;
        if (MSB_FIRST) begin
            w_chunk     = r_word[DATA_W-1 -: BITS_PER_CYC];
            w_word_next = r_word << BITS_PER_CYC;
        end else begin
            for (int i = 0; i < BITS_PER_CYC; i++) begin
                w_chunk[BITS_PER_CYC-1-i] = r_word[i];
            end
            w_word_next = r_word >> BITS_PER_CYC;
        end
    end

    assign w_crc_folded = crc_fold(r_crc, w_chunk);

    // Next-state and handshake qualifiers; clear overrides everything else.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fold       = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.i_data_valid & bus.i_enable & ~bus.i_clear;
                if (w_accept) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_fold  = bus.i_enable & ~bus.i_clear;
                w_final = w_fold & (r_cnt == LAST_CNT);
                if (w_final) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (bus.i_clear) begin
            w_next_state = ST_IDLE;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // State register.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: word latch, fold, counter and result publication.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_word      <= {DATA_W{1'b0}};
            r_crc       <= INIT;
            r_cnt       <= {CNT_W{1'b0}};
            r_last      <= 1'b0;
            r_crc_value <= {CRC_W{1'b0}};
            r_crc_valid <= 1'b0;
        end else begin
            r_crc_valid <= 1'b0;
            if (bus.i_clear) begin
                r_crc  <= INIT;
                r_cnt  <= {CNT_W{1'b0}};
                r_last <= 1'b0;
            end else if (w_accept) begin
                r_word <= bus.i_data;
                r_last <= bus.i_last;
                r_cnt  <= {CNT_W{1'b0}};
            end else if (w_fold) begin
                r_word <= w_word_next;
                if (w_final) begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (r_last) begin
                        r_crc_value <= w_crc_folded;
                        r_crc_valid <= 1'b1;
                        r_crc       <= INIT;
                    end else begin
                        r_crc <= w_crc_folded;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_crc <= w_crc_folded;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_param_engine.sv
// Scoreboard bench for crc_param_engine: default build plus BITS_PER_CYC=2 and =8 builds.
// Expected CRC values are hand-computed for x^5+x^2+1, seed 5'h1F.
module tb_crc_param_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc_param_engine_if #(.DATA_W(8), .CRC_W(5)) bus1 ();
    crc_param_engine_if #(.DATA_W(8), .CRC_W(5)) bus2 ();
    crc_param_engine_if #(.DATA_W(8), .CRC_W(5)) bus8 ();

    crc_param_engine #(.BITS_PER_CYC(1)) dut_b1 (.i_sys_clk(clk), .i_sys_rst(rst), .bus(bus1));
    crc_param_engine #(.BITS_PER_CYC(2)) dut_b2 (.i_sys_clk(clk), .i_sys_rst(rst), .bus(bus2));
    crc_param_engine #(.BITS_PER_CYC(8)) dut_b8 (.i_sys_clk(clk), .i_sys_rst(rst), .bus(bus8));

    typedef struct {
        logic [4:0] crc;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q8[$];
    exp_t e1, e2, e8;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic pv1 = 1'b0, pv2 = 1'b0, pv8 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus1.o_crc_valid === 1'b1) begin
            check("b1_strobe_expected", 32'(q1.size() > 0), 32'd1);
            check("b1_strobe_single", 32'(pv1), 32'd0);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("b1_crc_value", 32'(bus1.o_crc_value), 32'(e1.crc));
                check("b1_strobe_cycle", cyc, e1.cyc);
            end
        end
        pv1 <= bus1.o_crc_valid;
    end

    always @(negedge clk) begin
        if (bus2.o_crc_valid === 1'b1) begin
            check("b2_strobe_expected", 32'(q2.size() > 0), 32'd1);
            check("b2_strobe_single", 32'(pv2), 32'd0);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                check("b2_crc_value", 32'(bus2.o_crc_value), 32'(e2.crc));
                check("b2_strobe_cycle", cyc, e2.cyc);
            end
        end
        pv2 <= bus2.o_crc_valid;
    end

    always @(negedge clk) begin
        if (bus8.o_crc_valid === 1'b1) begin
            check("b8_strobe_expected", 32'(q8.size() > 0), 32'd1);
            check("b8_strobe_single", 32'(pv8), 32'd0);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check("b8_crc_value", 32'(bus8.o_crc_value), 32'(e8.crc));
                check("b8_strobe_cycle", cyc, e8.cyc);
            end
        end
        pv8 <= bus8.o_crc_valid;
    end

    // Send one word to the default build; optional enable stall or clear pulse relative to accept.
    task automatic send(input logic [7:0] d, input logic lst, input int stall_at,
                        input int stall_len, input int clear_at, input logic [4:0] exp_crc);
        int k;
        int acc;
        k = 0;
        bus1.i_data       = d;
        bus1.i_last       = lst;
        bus1.i_data_valid = 1'b1;
        while (bus1.o_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_timeout", 32'(k < 50), 32'd1);
        acc = cyc + 1;
        if (lst && clear_at < 0) q1.push_back('{exp_crc, acc + 8 + stall_len});
        @(negedge clk);
        bus1.i_data_valid = 1'b0;
        for (int j = 0; j < 8 + stall_len; j++) begin
            if (j == clear_at) begin
                bus1.i_clear = 1'b0;
                break;
            end
            check("ready_low_in_shift", 32'(bus1.o_ready), 32'd0);
            check("busy_in_shift", 32'(bus1.o_busy), 32'd1);
            if (j == stall_at) bus1.i_enable = 1'b0;
            if (j == stall_at + stall_len) bus1.i_enable = 1'b1;
            if (j == clear_at - 1) bus1.i_clear = 1'b1;
            @(negedge clk);
        end
        check("ready_after_word", 32'(bus1.o_ready), 32'd1);
        check("idle_after_word", 32'(bus1.o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.i_enable = 1'b1; bus1.i_clear = 1'b0; bus1.i_data = 8'h00;
        bus1.i_data_valid = 1'b0; bus1.i_last = 1'b0;
        bus2.i_enable = 1'b1; bus2.i_clear = 1'b0; bus2.i_data = 8'h00;
        bus2.i_data_valid = 1'b0; bus2.i_last = 1'b0;
        bus8.i_enable = 1'b1; bus8.i_clear = 1'b0; bus8.i_data = 8'h00;
        bus8.i_data_valid = 1'b0; bus8.i_last = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(bus1.o_ready), 32'd1);
        check("rst_busy", 32'(bus1.o_busy), 32'd0);
        check("rst_crc_value", 32'(bus1.o_crc_value), 32'd0);
        check("rst_crc_valid", 32'(bus1.o_crc_valid), 32'd0);
        check("rst_crc_reg", 32'(dut_b1.r_crc), 32'h1F);
        rst = 1'b0;
        @(negedge clk);

        send(8'hCB, 1'b1, -1, 0, -1, 5'h04);
        send(8'hCB, 1'b1, 2, 3, -1, 5'h04);
        send(8'hCB, 1'b0, -1, 0, -1, 5'h00);
        send(8'h00, 1'b1, -1, 0, -1, 5'h11);
        check("crc_reg_reinit", 32'(dut_b1.r_crc), 32'h1F);

        send(8'hCB, 1'b1, -1, 0, 4, 5'h00);
        check("clear_keeps_value", 32'(bus1.o_crc_value), 32'h11);
        check("clear_crc_reg", 32'(dut_b1.r_crc), 32'h1F);
        send(8'hCB, 1'b1, -1, 0, -1, 5'h04);

        bus1.i_data = 8'hCB; bus1.i_last = 1'b1;
        bus1.i_data_valid = 1'b1; bus1.i_clear = 1'b1;
        @(negedge clk);
        check("clear_blocks_accept", 32'(bus1.o_busy), 32'd0);
        bus1.i_data_valid = 1'b0; bus1.i_clear = 1'b0;
        @(negedge clk);

        bus2.i_data = 8'hCB; bus2.i_last = 1'b1; bus2.i_data_valid = 1'b1;
        bus8.i_data = 8'hCB; bus8.i_last = 1'b1; bus8.i_data_valid = 1'b1;
        q2.push_back('{5'h04, cyc + 1 + 4});
        q8.push_back('{5'h04, cyc + 1 + 1});
        @(negedge clk);
        bus2.i_data_valid = 1'b0;
        bus8.i_data_valid = 1'b0;
        check("b2_accepted", 32'(bus2.o_busy), 32'd1);
        check("b8_accepted", 32'(bus8.o_busy), 32'd1);
        repeat (6) @(negedge clk);

        bus1.i_data = 8'hCB; bus1.i_last = 1'b1; bus1.i_data_valid = 1'b1;
        @(negedge clk);
        bus1.i_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus1.o_busy), 32'd0);
        check("async_rst_ready", 32'(bus1.o_ready), 32'd1);
        check("async_rst_value", 32'(bus1.o_crc_value), 32'd0);
        check("async_rst_valid", 32'(bus1.o_crc_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'hCB, 1'b1, -1, 0, -1, 5'h04);

        repeat (12) @(negedge clk);
        check("b1_queue_drained", q1.size(), 32'd0);
        check("b2_queue_drained", q2.size(), 32'd0);
        check("b8_queue_drained", q8.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
